// File: rtl/kf_flit_ejector.sv
// kf_flit_ejector: local-port spike flit ejector with destination check, FWFT FIFO
// and accept/misroute counters.
package kf_pkg;
  localparam int KF_NEURON_ID_BITS = 10;
  typedef struct packed {
    logic [7:0]                   dest_x;
    logic [7:0]                   dest_y;
    logic [KF_NEURON_ID_BITS-1:0] neuron_id;
    logic [7:0]                   payload;
  } spike_flit_t;
endpackage

module kf_flit_ejector
  import kf_pkg::*;
#(
  parameter logic [7:0] TILE_X   = 8'd0,
  parameter logic [7:0] TILE_Y   = 8'd0,
  parameter int         DEPTH    = 8,
  parameter bit         BCAST_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         flit_in_valid,
  output logic                         flit_in_ready,
  input  spike_flit_t                  flit_in_flit,
  output logic                         spike_valid,
  input  logic                         spike_ready,
  output logic [KF_NEURON_ID_BITS-1:0] spike_pre_id,
  output logic [7:0]                   spike_payload,
  output logic [$clog2(DEPTH):0]       occupancy,
  output logic [15:0]                  accept_cnt,
  output logic [15:0]                  misroute_cnt,
  output logic                         misroute_pulse
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = KF_NEURON_ID_BITS + 8;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   occ_q, occ_d;
  logic [15:0]   acc_q, acc_d, mis_q, mis_d;
  logic          pulse_q, pulse_d;
  logic          hit, push, miss, pop;
  always_comb begin
    hit = (flit_in_flit.dest_x == TILE_X && flit_in_flit.dest_y == TILE_Y) ||
          (BCAST_EN && flit_in_flit.dest_x == 8'hFF && flit_in_flit.dest_y == 8'hFF);
    flit_in_ready = (occ_q != FULL) && !flush && !rst;
    push = flit_in_valid && flit_in_ready && hit;
    miss = flit_in_valid && flit_in_ready && !hit;
    pop = spike_valid && spike_ready && !flush;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {flit_in_flit.neuron_id, flit_in_flit.payload};
    wr_d = flush ? '0 : wr_q + AW'(push);
    rd_d = flush ? '0 : rd_q + AW'(pop);
    occ_d = flush ? '0 : occ_q + (AW+1)'(push) - (AW+1)'(pop);
    acc_d = acc_q + 16'(push);
    mis_d = mis_q + 16'(miss && mis_q != 16'hFFFF);
    pulse_d = miss;
  end
  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk)
    mem_q <= mem_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      occ_q <= '0;
      acc_q <= '0;
      mis_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      occ_q <= occ_d;
      acc_q <= acc_d;
      mis_q <= mis_d;
      pulse_q <= pulse_d;
    end
  assign spike_valid = occ_q != '0;
  assign {spike_pre_id, spike_payload} = mem_q[rd_q];
  assign occupancy = occ_q;
  assign accept_cnt = acc_q;
  assign misroute_cnt = mis_q;
  assign misroute_pulse = pulse_q;
  always @(posedge clk)
    if (!rst) begin
      assert (occ_q <= FULL);
      assert (!(pop && occ_q == '0));
    end
endmodule

// File: tb/tb_kf_flit_ejector.sv
// tb_kf_flit_ejector: vector table, directed corner sequences and random traffic
// checked against a queue-based reference model.
module tb_kf_flit_ejector;
  import kf_pkg::*;
  localparam logic [7:0] TX = 8'd2;
  localparam logic [7:0] TY = 8'd1;
  localparam int DEPTH = 8;
  typedef logic [KF_NEURON_ID_BITS-1:0] nid_t;
  typedef struct {
    nid_t       nid;
    logic [7:0] pl;
  } ent_t;
  typedef struct {
    logic v;
    logic [7:0] dx, dy;
    nid_t nid;
    logic [7:0] pl;
    logic sr;
    logic [3:0] e_occ;
    logic e_sv, e_pulse;
    logic [15:0] e_acc, e_mis;
  } vec_t;

  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, valid = 1'b0, sready = 1'b0, v2 = 1'b0;
  spike_flit_t flit = '0;
  logic ready, sv, pulse_o;
  nid_t pre_id;
  logic [7:0] payload;
  logic [3:0] occ;
  logic [15:0] acc_o, mis_o;
  logic ready2, sv2, pulse2;
  nid_t pre_id2;
  logic [7:0] payload2;
  logic [3:0] occ2;
  logic [15:0] acc2, mis2;

  kf_flit_ejector #(.TILE_X(TX), .TILE_Y(TY), .DEPTH(DEPTH), .BCAST_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flit_in_valid(valid), .flit_in_ready(ready),
    .flit_in_flit(flit), .spike_valid(sv), .spike_ready(sready), .spike_pre_id(pre_id),
    .spike_payload(payload), .occupancy(occ), .accept_cnt(acc_o), .misroute_cnt(mis_o),
    .misroute_pulse(pulse_o));

  kf_flit_ejector #(.TILE_X(TX), .TILE_Y(TY), .DEPTH(DEPTH), .BCAST_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .flush(1'b0), .flit_in_valid(v2), .flit_in_ready(ready2),
    .flit_in_flit(flit), .spike_valid(sv2), .spike_ready(1'b1), .spike_pre_id(pre_id2),
    .spike_payload(payload2), .occupancy(occ2), .accept_cnt(acc2), .misroute_cnt(mis2),
    .misroute_pulse(pulse2));

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  ent_t q[$];
  nid_t popped[$];
  int acc = 0, mis = 0;
  bit pulse = 1'b0, last_hs = 1'b0;
  vec_t tbl[6];

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic put(logic v, logic [7:0] dx, logic [7:0] dy, nid_t nid, logic [7:0] pl);
    valid = v;
    flit = '{dest_x: dx, dest_y: dy, neuron_id: nid, payload: pl};
  endtask

  task automatic chk_out();
    chk("occupancy", 32'(occ), 32'(q.size()));
    chk("spike_valid", 32'(sv), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("pre_id", 32'(pre_id), 32'(q[0].nid));
      chk("payload", 32'(payload), 32'(q[0].pl));
    end
    chk("accept_cnt", 32'(acc_o), 32'(acc));
    chk("misroute_cnt", 32'(mis_o), 32'(mis));
    chk("misroute_pulse", 32'(pulse_o), 32'(pulse));
  endtask

  // One clock: predict handshakes from the model, advance, then compare.
  task automatic cyc();
    bit rdy, h, pp;
    #1;
    rdy = q.size() < DEPTH && !flush;
    h = (flit.dest_x == TX && flit.dest_y == TY) || (flit.dest_x == 8'hFF && flit.dest_y == 8'hFF);
    pp = q.size() > 0 && sready && !flush;
    last_hs = valid && rdy;
    chk("flit_in_ready", 32'(ready), 32'(rdy));
    if (pp) popped.push_back(pre_id);
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (last_hs && h) begin
        q.push_back('{flit.neuron_id, flit.payload});
        acc = (acc + 1) % 65536;
      end
    end
    if (last_hs && !h && mis < 65535) mis++;
    pulse = last_hs && !h;
    chk_out();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    acc = 0;
    mis = 0;
    pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("ready_after_rst", 32'(ready), 32'd1);
    chk_out();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int idx, n, acc_before;
    tbl[0] = '{1'b1, TX, TY, nid_t'(5), 8'h3C, 1'b1, 4'd1, 1'b1, 1'b0, 16'd1, 16'd0};
    tbl[1] = '{1'b0, TX, TY, nid_t'(0), 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 16'd1, 16'd0};
    tbl[2] = '{1'b1, TX + 8'd1, TY, nid_t'(7), 8'h11, 1'b1, 4'd0, 1'b0, 1'b1, 16'd1, 16'd1};
    tbl[3] = '{1'b0, TX, TY, nid_t'(0), 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 16'd1, 16'd1};
    tbl[4] = '{1'b1, 8'hFF, 8'hFF, nid_t'(9), 8'hA5, 1'b0, 4'd1, 1'b1, 1'b0, 16'd2, 16'd1};
    tbl[5] = '{1'b0, TX, TY, nid_t'(0), 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 16'd2, 16'd1};
    #1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      put(tbl[i].v, tbl[i].dx, tbl[i].dy, tbl[i].nid, tbl[i].pl);
      sready = tbl[i].sr;
      cyc();
      chk("tbl_occ", 32'(occ), 32'(tbl[i].e_occ));
      chk("tbl_sv", 32'(sv), 32'(tbl[i].e_sv));
      chk("tbl_pulse", 32'(pulse_o), 32'(tbl[i].e_pulse));
      chk("tbl_acc", 32'(acc_o), 32'(tbl[i].e_acc));
      chk("tbl_mis", 32'(mis_o), 32'(tbl[i].e_mis));
    end
    // Fill to full with the core stalled, then drain while the rest stream in.
    sready = 1'b0;
    idx = 0;
    popped.delete();
    for (int c = 0; c < 12; c++) begin
      put(1'b1, TX, TY, nid_t'(idx), 8'(idx + 16));
      cyc();
      if (last_hs) idx++;
    end
    chk("full_accepts", 32'(idx), 32'd8);
    chk("full_occ", 32'(occ), 32'd8);
    chk("full_ready", 32'(ready), 32'd0);
    sready = 1'b1;
    for (int c = 0; c < 40 && popped.size() < 10; c++) begin
      put(idx < 10, TX, TY, nid_t'(idx), 8'(idx + 16));
      cyc();
      if (last_hs) idx++;
    end
    chk("drain_count", 32'(popped.size()), 32'd10);
    for (int i = 0; i < 10 && i < popped.size(); i++) chk("drain_order", 32'(popped[i]), 32'(i));
    // Steady push+pop at occupancy 4 across pointer wrap.
    put(1'b0, TX, TY, '0, '0);
    sready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, TX, TY, nid_t'(100 + i), 8'(i));
      cyc();
    end
    sready = 1'b1;
    for (int i = 4; i < 24; i++) begin
      put(1'b1, TX, TY, nid_t'(100 + i), 8'(i));
      cyc();
      chk("pp_occ", 32'(occ), 32'd4);
    end
    put(1'b0, TX, TY, '0, '0);
    for (int c = 0; c < 10 && q.size() > 0; c++) cyc();
    chk("pp_drained", 32'(occ), 32'd0);
    // Flush at occupancy 3 with a flit offered.
    sready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, TX, TY, nid_t'(200 + i), 8'(i));
      cyc();
    end
    chk("pre_flush_occ", 32'(occ), 32'd3);
    acc_before = acc;
    flush = 1'b1;
    sready = 1'b1;
    put(1'b1, TX, TY, nid_t'(300), 8'h77);
    cyc();
    flush = 1'b0;
    put(1'b0, TX, TY, '0, '0);
    chk("flush_occ", 32'(occ), 32'd0);
    chk("flush_sv", 32'(sv), 32'd0);
    chk("flush_acc", 32'(acc_o), 32'(acc_before));
    // Broadcast on an instance with broadcast disabled is a misroute.
    put(1'b0, 8'hFF, 8'hFF, nid_t'(42), 8'h42);
    v2 = 1'b1;
    cyc();
    v2 = 1'b0;
    chk("nobcast_mis", 32'(mis2), 32'd1);
    chk("nobcast_occ", 32'(occ2), 32'd0);
    chk("nobcast_pulse", 32'(pulse2), 32'd1);
    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      n = $urandom_range(0, 3);
      put(1'($urandom_range(0, 1)), n == 0 ? TX : (n == 1 ? 8'hFF : 8'($urandom_range(0, 3))),
          n == 0 ? TY : (n == 1 ? 8'hFF : 8'($urandom_range(0, 2))),
          nid_t'($urandom), 8'($urandom));
      sready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      cyc();
    end
    flush = 1'b0;
    // Misroute counter saturation.
    sready = 1'b1;
    put(1'b1, TX + 8'd1, TY, nid_t'(1), 8'h01);
    for (int c = 0; c < 70000 && mis < 65535; c++) cyc();
    chk("mis_at_max", 32'(mis_o), 32'h0000FFFF);
    cyc();
    chk("mis_saturated", 32'(mis_o), 32'h0000FFFF);
    chk("mis_sat_pulse", 32'(pulse_o), 32'd1);
    // Asynchronous reset mid-stream.
    sready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, i == 2 ? TX + 8'd1 : TX, TY, nid_t'(400 + i), 8'(i));
      cyc();
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_occ", 32'(occ), 32'd0);
    chk("arst_sv", 32'(sv), 32'd0);
    chk("arst_acc", 32'(acc_o), 32'd0);
    chk("arst_mis", 32'(mis_o), 32'd0);
    chk("arst_pulse", 32'(pulse_o), 32'd0);
    chk("arst_ready", 32'(ready), 32'd0);
    put(1'b0, TX, TY, '0, '0);
    do_reset();
    sready = 1'b1;
    put(1'b1, TX, TY, nid_t'(11), 8'h5A);
    cyc();
    chk("post_rst_id", 32'(pre_id), 32'd11);
    put(1'b0, TX, TY, '0, '0);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
